noc_packet_sink: RTL and testbench

- Edge-of-mesh packet receiver: the far end of the credit-based flit link that the MA/App injectors drive into the many-core.
- Attached to a many-core output port (tx/credit/data), it accepts flits under credit flow control and frames them into packets (header, size, payload).
- Buffers tagged flits in a FIFO and presents them to a consumer (testbench monitor or host bridge) on a valid/ready stream marked with start/end of packet.
- Keeps packet and error counters for end-of-simulation checks.

---
 rtl/noc_packet_sink.sv | 138 +++++++++++++
 tb/tb_noc_packet_sink.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/noc_packet_sink.sv
// rtl/noc_packet_sink.sv - credit-flow flit receiver with packet framing, tagged FIFO and counters
module noc_packet_sink #(
  parameter int FLIT_SIZE    = 32,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic                 credit_o,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [FLIT_SIZE-1:0] out_data_o,
  output logic                 out_sop_o,
  output logic                 out_eop_o,
  output logic [15:0]          pkt_count_o,
  output logic                 overflow_o
);

  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam int EW = FLIT_SIZE + 2;
  localparam logic [CW-1:0] FULL_CNT = CW'(BUFFER_DEPTH);

  typedef enum logic [1:0] {ST_HDR, ST_SIZE, ST_PAYLOAD} state_e;

  state_e               state_q, state_d;
  logic [FLIT_SIZE-1:0] rem_q, rem_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [EW-1:0]        mem_q [BUFFER_DEPTH];
  logic [EW-1:0]        mem_d [BUFFER_DEPTH];
  logic [15:0]          pkt_count_q, pkt_count_d;
  logic                 overflow_q, overflow_d;
  logic                 push, pop, empty;
  logic                 tag_sop, tag_eop;
  logic [EW-1:0]        head;

  // Credit comes from registered occupancy only, so a same-cycle pop never reopens it.
  assign credit_o = (count_q != FULL_CNT);
  assign empty    = (count_q == '0);
  assign push     = rx_i & credit_o;
  assign pop      = ~empty & out_ready_i;
  assign head     = mem_q[rd_ptr_q];

  // Parser state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_HDR;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Parser next state; advances only on accepted flits
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (push) begin
      case (state_q)
        ST_HDR: state_d = ST_SIZE;
        ST_SIZE: begin
          rem_d   = data_i;
          state_d = (data_i == '0) ? ST_HDR : ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          rem_d = rem_q - FLIT_SIZE'(1);
          if (rem_q == FLIT_SIZE'(1)) state_d = ST_HDR;
        end
        default: state_d = ST_HDR;
      endcase
    end
  end

  // Parser outputs: tags for the flit currently on data_i
  always_comb begin
    tag_sop = 1'b0;
    tag_eop = 1'b0;
    case (state_q)
      ST_HDR:     tag_sop = 1'b1;
      ST_SIZE:    tag_eop = (data_i == '0);
      ST_PAYLOAD: tag_eop = (rem_q == FLIT_SIZE'(1));
      default:    tag_sop = 1'b0;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {tag_sop, tag_eop, data_i};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    pkt_count_d = pkt_count_q;
    overflow_d  = overflow_q | (rx_i & ~credit_o);
    if (pop && head[EW-2]) pkt_count_d = pkt_count_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_count_q <= pkt_count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Head fields are masked to zero whenever the FIFO is empty.
  assign out_valid_o = ~empty;
  assign out_data_o  = empty ? '0 : head[FLIT_SIZE-1:0];
  assign out_sop_o   = ~empty & head[EW-1];
  assign out_eop_o   = ~empty & head[EW-2];
  assign pkt_count_o = pkt_count_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_noc_packet_sink.sv
// tb/tb_noc_packet_sink.sv - scoreboard bench for noc_packet_sink
module tb_noc_packet_sink;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        rx_i;
  logic        credit_o;
  logic [31:0] data_i;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_data_o;
  logic        out_sop_o;
  logic        out_eop_o;
  logic [15:0] pkt_count_o;
  logic        overflow_o;

  noc_packet_sink #(.FLIT_SIZE(32), .BUFFER_DEPTH(8)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (rx_i),
    .credit_o    (credit_o),
    .data_i      (data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_sop_o   (out_sop_o),
    .out_eop_o   (out_eop_o),
    .pkt_count_o (pkt_count_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_errors = 0;
  int          ready_mode = 0;
  logic [33:0] sb [$];
  int          m_state = 0;
  logic [31:0] m_rem = 0;
  int          exp_pkts = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Consumer: ready is chosen at the falling edge; a pop happens at the next rising edge.
  always @(negedge clk_i) begin
    logic [33:0] e;
    case (ready_mode)
      0:       out_ready_i = 1'b1;
      1:       out_ready_i = 1'b0;
      default: out_ready_i = 1'($urandom_range(0, 1));
    endcase
    if (rst_ni && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_flit", {30'd0, out_sop_o, out_eop_o, out_data_o}, 64'h3_FFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("flit", {30'd0, out_sop_o, out_eop_o, out_data_o}, {30'd0, e});
        if (e[32]) exp_pkts++;
      end
    end
  end

  // Drive one flit at a falling edge, waiting for credit; the model tags and queues it.
  task automatic send_flit(input logic [31:0] d);
    logic sop, eop;
    int   w = 0;
    rx_i = 1'b0;
    while (!credit_o && w < 1000) begin
      @(negedge clk_i);
      w++;
    end
    check("credit_wait_timeout", 64'(credit_o), 64'd1);
    sop = 1'b0;
    eop = 1'b0;
    case (m_state)
      0: begin sop = 1'b1; m_state = 1; end
      1: begin
        if (d == 0) begin eop = 1'b1; m_state = 0; end
        else begin m_rem = d; m_state = 2; end
      end
      default: begin
        if (m_rem == 1) begin eop = 1'b1; m_state = 0; end
        m_rem = m_rem - 1;
      end
    endcase
    sb.push_back({sop, eop, d});
    rx_i   = 1'b1;
    data_i = d;
    @(negedge clk_i);
    rx_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid_o) && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_timeout", 64'(n < 5000), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    rx_i   = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_credit", 64'(credit_o), 64'd1);
    check("rst_pkt", 64'(pkt_count_o), 64'd0);
    sb.delete();
    m_state  = 0;
    m_rem    = 0;
    exp_pkts = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    rx_i   = 1'b0;
    data_i = '0;
    repeat (2) @(negedge clk_i);
    check("reset_credit", 64'(credit_o), 64'd1);
    check("reset_valid", 64'(out_valid_o), 64'd0);
    check("reset_sop", 64'(out_sop_o), 64'd0);
    check("reset_eop", 64'(out_eop_o), 64'd0);
    check("reset_data", 64'(out_data_o), 64'd0);
    check("reset_pkt", 64'(pkt_count_o), 64'd0);
    check("reset_ovf", 64'(overflow_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Single packet, consumer always ready
    ready_mode = 0;
    @(negedge clk_i);
    check("t1_idle_valid", 64'(out_valid_o), 64'd0);
    send_flit(32'h0000_0102);
    check("t1_latency_valid", 64'(out_valid_o), 64'd1);
    send_flit(32'd3);
    send_flit(32'hA);
    send_flit(32'hB);
    send_flit(32'hC);
    drain();
    check("t1_pkt", 64'(pkt_count_o), 64'd1);
    check("t1_ovf", 64'(overflow_o), 64'd0);

    // Zero-size packet, then a follow-up packet must start with sop
    do_reset();
    send_flit(32'h0000_0201);
    send_flit(32'd0);
    drain();
    check("t2_pkt", 64'(pkt_count_o), 64'd1);
    send_flit(32'h0000_0202);
    send_flit(32'd1);
    send_flit(32'h55);
    drain();
    check("t2_pkt2", 64'(pkt_count_o), 64'd2);

    // Backpressure: 12-flit packet into an 8-deep FIFO
    do_reset();
    ready_mode = 1;
    send_flit(32'h0000_0404);
    send_flit(32'd10);
    for (int i = 0; i < 6; i++) send_flit(32'h100 + i);
    check("t3_credit_full", 64'(credit_o), 64'd0);
    check("t3_valid_full", 64'(out_valid_o), 64'd1);
    ready_mode = 0;
    for (int i = 6; i < 10; i++) send_flit(32'h100 + i);
    drain();
    check("t3_pkt", 64'(pkt_count_o), 64'd1);

    // Credit violation: the dropped 0xDEAD flit never reaches the scoreboard
    do_reset();
    check("t4_ovf_after_reset", 64'(overflow_o), 64'd0);
    ready_mode = 1;
    send_flit(32'h0000_0505);
    send_flit(32'd6);
    for (int i = 0; i < 6; i++) send_flit(32'h200 + i);
    check("t4_credit_full", 64'(credit_o), 64'd0);
    rx_i   = 1'b1;
    data_i = 32'hDEAD;
    @(negedge clk_i);
    rx_i = 1'b0;
    check("t4_ovf_set", 64'(overflow_o), 64'd1);
    ready_mode = 0;
    drain();
    repeat (5) @(negedge clk_i);
    check("t4_ovf_sticky", 64'(overflow_o), 64'd1);
    check("t4_pkt", 64'(pkt_count_o), 64'd1);

    // 1000 back-to-back packets with random ready
    do_reset();
    ready_mode = 2;
    for (int p = 0; p < 1000; p++) begin
      int sz = $urandom_range(0, 20);
      send_flit($urandom);
      send_flit(32'(sz));
      for (int k = 0; k < sz; k++) send_flit($urandom);
    end
    drain();
    check("t5_pkt", 64'(pkt_count_o), 64'd1000);
    check("t5_model_pkt", 64'(pkt_count_o), 64'(exp_pkts));
    check("t5_ovf", 64'(overflow_o), 64'd0);

    // Reset in the middle of a payload
    do_reset();
    ready_mode = 1;
    send_flit(32'h0000_0606);
    send_flit(32'd5);
    send_flit(32'h301);
    send_flit(32'h302);
    do_reset();
    ready_mode = 0;
    send_flit(32'h0000_0303);
    send_flit(32'd1);
    send_flit(32'h7777);
    drain();
    check("t6_pkt", 64'(pkt_count_o), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
